// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared state encoding, Avalon word addresses and wait-counter width for the system-ID boot checker
package sysid_checker_pkg;
  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, RETRY, FINISH} state_t;
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;
  localparam int WAIT_W = 16;
endpackage

// File: rtl/sysid_wait_timer.sv
// sysid_wait_timer: counts stalled read cycles; expired flags the stall cycle that reaches limit
// Ports: clock, reset_n (async active-low), clr (zero the count), en (count this cycle),
//        limit (cycles allowed), expired (this enabled cycle is the limit-th one)
module sysid_wait_timer
  import sysid_checker_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [WAIT_W-1:0] limit,
  output logic              expired
);
  logic [WAIT_W-1:0] cnt;
  // Fires alongside the enable so the FSM leaves the read state on the same edge the count reaches limit
  assign expired = en && (cnt == limit - WAIT_W'(1));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + WAIT_W'(1) : cnt;
endmodule

// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: Avalon-MM master reading system-ID words 0 and 1 and comparing them to build-time constants
// Ports: clock, reset_n (async active-low); start pulse; Avalon read master (avm_*);
//        status busy/done/id_ok/ts_ok/timeout_err/retry_cnt; captured_id/captured_ts hold the last accepted reads.
// Build option: define SYSID_AUTOSTART_EN to launch one check automatically in the second clock after reset release.
module sysid_boot_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1328261165,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [3:0]  retry_cnt,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);
  state_t state;
  logic go, accept, stall, expired;
  assign accept = avm_read & ~avm_waitrequest;
  assign stall  = avm_read & avm_waitrequest;
`ifdef SYSID_AUTOSTART_EN
  logic [1:0] auto_sr;
  // Fills with ones after reset; the single 01 pattern is the one-shot start
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) auto_sr <= 2'b00;
    else auto_sr <= {auto_sr[0], 1'b1};
  assign go = start | (auto_sr[0] & ~auto_sr[1]);
`else
  assign go = start;
`endif
  // Any cycle that is not a stalled read clears the count, so each read state starts from zero
  sysid_wait_timer u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (~stall),
    .en      (stall),
    .limit   (WAIT_W'(TIMEOUT_CYCLES)),
    .expired (expired)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= IDLE;
      avm_address <= ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      retry_cnt   <= 4'd0;
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
    end else begin
      case (state)
        IDLE: if (go) begin
          state       <= RD_ID;
          avm_read    <= 1'b1;
          avm_address <= ADDR_ID;
          busy        <= 1'b1;
          done        <= 1'b0;
          id_ok       <= 1'b0;
          ts_ok       <= 1'b0;
          timeout_err <= 1'b0;
          retry_cnt   <= 4'd0;
        end
        RD_ID: if (accept) begin
          captured_id <= avm_readdata;
          avm_address <= ADDR_TS;
          state       <= RD_TS;
        end else if (expired) begin
          avm_read <= 1'b0;
          state    <= RETRY;
        end
        RD_TS: if (accept) begin
          captured_ts <= avm_readdata;
          avm_read    <= 1'b0;
          avm_address <= ADDR_ID;
          state       <= CHECK;
        end else if (expired) begin
          avm_read    <= 1'b0;
          avm_address <= ADDR_ID;
          state       <= RETRY;
        end
        CHECK: begin
          id_ok <= captured_id == EXPECTED_ID;
          ts_ok <= captured_ts == EXPECTED_TS;
          state <= FINISH;
        end
        RETRY: if (retry_cnt == 4'(MAX_RETRIES)) begin
          timeout_err <= 1'b1;
          id_ok       <= 1'b0;
          ts_ok       <= 1'b0;
          state       <= FINISH;
        end else begin
          retry_cnt   <= retry_cnt + 4'd1;
          avm_read    <= 1'b1;
          avm_address <= ADDR_ID;
          state       <= RD_ID;
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: directed table-driven checks of the system-ID boot checker against a modelled slave
module tb_sysid_boot_checker;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1328261165;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic busy, done, id_ok, ts_ok, timeout_err;
  logic [3:0] retry_cnt;
  logic [31:0] captured_id, captured_ts;

  logic [31:0] id_val = 32'd0;
  logic [31:0] ts_val = 32'd0;
  logic [7:0] stall_cfg = 8'd0;
  logic [7:0] stall_left = 8'd0;
  logic stuck = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sysid_boot_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (8),
    .MAX_RETRIES    (2)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout_err     (timeout_err),
    .retry_cnt       (retry_cnt),
    .captured_id     (captured_id),
    .captured_ts     (captured_ts)
  );

  // Slave model: each read stalls stall_cfg cycles, or forever while stuck
  assign avm_waitrequest = stuck || (avm_read && stall_left != 8'd0);
  assign avm_readdata = avm_address ? ts_val : id_val;
  always @(posedge clock)
    if (!avm_read || !avm_waitrequest) stall_left <= stall_cfg;
    else if (!stuck) stall_left <= stall_left - 8'd1;

  // Read-cycle counters per address and a stability monitor across stalls
  logic mon_clr = 1'b0;
  int id_rd = 0, ts_rd = 0, unstable = 0;
  logic p_stall = 1'b0, p_addr = 1'b0;
  always @(negedge clock) begin
    if (mon_clr) begin
      id_rd = 0;
      ts_rd = 0;
      unstable = 0;
    end else begin
      if (avm_read && avm_address) ts_rd++;
      if (avm_read && !avm_address) id_rd++;
      if (p_stall && !(avm_read && avm_address == p_addr)) unstable++;
    end
    p_stall = avm_read && avm_waitrequest;
    p_addr = avm_address;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 200) begin
      @(negedge clock);
      lat++;
    end
  endtask

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic [7:0]  stall;
    int          lat;
    logic        id_ok;
    logic        ts_ok;
  } row_t;

  row_t rows[5];

  initial begin
    int lat, att, gap, bad_gap;
    logic pr;
    rows[0] = '{32'd0,          32'd1328261165, 8'd0, 4,  1'b1, 1'b1};
    rows[1] = '{32'd0,          32'd1328261166, 8'd0, 4,  1'b1, 1'b0};
    rows[2] = '{32'hFFFF_FFFF,  32'd0,          8'd1, 6,  1'b0, 1'b0};
    rows[3] = '{32'd5,          32'd1328261165, 8'd0, 4,  1'b0, 1'b1};
    rows[4] = '{32'd0,          32'd1328261165, 8'd3, 10, 1'b1, 1'b1};

    repeat (2) @(negedge clock);
    chk("reset_outputs", {27'd0, avm_read, busy, done, id_ok, ts_ok}, 32'd0);
    chk("reset_retry_err", {27'd0, timeout_err, retry_cnt}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_no_start", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      id_val = rows[i].id;
      ts_val = rows[i].ts;
      stall_cfg = rows[i].stall;
      mon_clr = 1'b1;
      @(negedge clock);
      mon_clr = 1'b0;
      pulse_start();
      chk($sformatf("row%0d_busy_after_start", i), {30'd0, busy, done}, 32'd2);
      wait_done(lat);
      chk($sformatf("row%0d_latency", i), lat, rows[i].lat);
      chk($sformatf("row%0d_id_ok", i), id_ok, rows[i].id_ok);
      chk($sformatf("row%0d_ts_ok", i), ts_ok, rows[i].ts_ok);
      chk($sformatf("row%0d_err_retry", i), {timeout_err, retry_cnt}, 32'd0);
      chk($sformatf("row%0d_busy_end", i), busy, 1'b0);
      chk($sformatf("row%0d_captured_id", i), captured_id, rows[i].id);
      chk($sformatf("row%0d_captured_ts", i), captured_ts, rows[i].ts);
      chk($sformatf("row%0d_id_read_cycles", i), id_rd, rows[i].stall + 1);
      chk($sformatf("row%0d_ts_read_cycles", i), ts_rd, rows[i].stall + 1);
      chk($sformatf("row%0d_addr_stable", i), unstable, 0);
    end

    // Waitrequest stuck high: three attempts separated by one idle RETRY cycle each
    stuck = 1'b1;
    @(negedge clock);
    pulse_start();
    att = 0;
    gap = 0;
    bad_gap = 0;
    pr = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (avm_read && !pr) begin
        att++;
        if (att > 1 && gap != 1) bad_gap++;
        gap = 0;
      end else if (!avm_read) gap++;
      pr = avm_read;
      @(negedge clock);
    end
    chk("timeout_done", done, 1'b1);
    chk("timeout_attempts", att, 3);
    chk("timeout_gaps", bad_gap, 0);
    chk("timeout_err", timeout_err, 1'b1);
    chk("timeout_retry_cnt", retry_cnt, 4'd2);
    chk("timeout_oks", {id_ok, ts_ok}, 2'b00);
    stuck = 1'b0;

    // Next start clears the sticky error status on the same edge
    id_val = EXP_ID;
    ts_val = EXP_TS;
    stall_cfg = 8'd0;
    @(negedge clock);
    pulse_start();
    chk("restart_clears", {timeout_err, retry_cnt, done}, 32'd0);
    wait_done(lat);
    chk("restart_latency", lat, 4);
    chk("restart_pass", {id_ok, ts_ok}, 2'b11);

    // Reset during a stalled timestamp read
    stall_cfg = 8'd5;
    @(negedge clock);
    pulse_start();
    repeat (7) @(negedge clock);
    chk("mid_rd_ts_state", {avm_read, avm_address}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_flags", {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout_err, retry_cnt}, 32'd0);
    chk("mid_reset_captured", {captured_id | captured_ts}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    stall_cfg = 8'd0;
    repeat (2) @(negedge clock);
    chk("after_reset_idle", {busy, avm_read}, 2'b00);
    pulse_start();
    wait_done(lat);
    chk("after_reset_latency", lat, 4);
    chk("after_reset_pass", {id_ok, ts_ok, timeout_err}, 3'b110);

    // Start re-issued while busy and during FINISH is ignored
    stall_cfg = 8'd3;
    @(negedge clock);
    pulse_start();
    lat = 0;
    while (!done && lat < 100) begin
      start = (lat == 2 || lat == 6 || lat == 9);
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    chk("busy_start_latency", lat, 10);
    chk("busy_start_pass", {id_ok, ts_ok, timeout_err}, 3'b110);
    repeat (3) @(negedge clock);
    chk("finish_start_ignored", {busy, avm_read, done}, 3'b001);

`ifdef SYSID_AUTOSTART_EN
    stall_cfg = 8'd0;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    wait_done(lat);
    chk("autostart_latency", lat, 6);
    chk("autostart_pass", {id_ok, ts_ok}, 2'b11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
